decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I instruction-decode pipeline stage, directly upstream of the register file.
//  - Accepts fetched instructions over a valid/ready handshake and latches them in an IF/ID register.
//  - Drives the register-file read addresses, decodes fields, control signals and the immediate.
//  - Captures operands into an ID/EX output register; inserts a bubble on load-use hazards.
// PARAMETERS
//  XLEN    32  datapath / operand width
//  PC_W    32  program-counter width
//  RADDR_W 5   register address width
// PORTS
//  clk              in   1        rising-edge clock
//  reset            in   1        synchronous, active-high reset
//  instrValid       in   1        fetch presents instr/pcIn
//  instrReady       out  1        stage accepts instr this cycle
//  instr            in   32       raw instruction word
//  pcIn             in   PC_W     PC of instr
//  flush            in   1        kill all in-flight instructions (branch redirect)
//  readRegister1    out  RADDR_W  register-file read address rs1
//  readRegister2    out  RADDR_W  register-file read address rs2
//  readData1        in   XLEN     register-file data rs1 (combinational read)
//  readData2        in   XLEN     register-file data rs2
//  wbRegWrite       in   1        writeback write enable (bypass source)
//  wbWriteRegister  in   RADDR_W  writeback destination
//  wbWriteData      in   XLEN     writeback data
//  outValid         out  1        ID/EX register holds a valid instruction
//  outReady         in   1        execute stage consumes this cycle
//  outPc            out  PC_W     PC of decoded instruction
//  outOp1, outOp2   out  XLEN     rs1 / rs2 operand values
//  outImm           out  XLEN     sign-extended immediate
//  outRd, outRs1, outRs2  out RADDR_W  register fields
//  outOpcode        out  7        opcode
//  outFunct3        out  3        funct3
//  outFunct7        out  7        funct7
//  outRegWrite      out  1        instruction writes rd
//  outMemRead       out  1        load
//  outMemWrite      out  1        store
//  outIllegal       out  1        opcode not in RV32I set
// BEHAVIOUR
//  - Reset: fdValid=0, outValid=0, all out* data=0; instrReady=0 while reset high, 1 the cycle after.
//  - Accept: instrValid&&instrReady at edge N -> fd register loaded.
//    - Decoded result visible on out* after edge N+1 (2-stage, 1 instr/cycle sustained).
//  - advance = fdValid && !loadUse && (!outValid || outReady).
//    - instrReady = !flush && (!fdValid || advance).
//  - ID/EX register:
//    - advance -> load decode.
//    - else outValid&&outReady -> outValid<=0 (bubble).
//    - else hold all out* stable.
//  - readRegister1/2 = fd instr[19:15]/[24:20], combinational from fd register (valid even when fdValid=0).
//  - Operand selection:
//    - rs==0 -> 0 (x0 forced, regardless of register-file content).
//    - else readData.
//  - Immediate: I/S/B/U/J formats sign-extended to XLEN; R-type -> 0.
//  - Control decode:
//    - regWrite for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
//    - memRead for LOAD; memWrite for STORE.
//  - Operand usage:
//    - rs1 used by all except LUI/AUIPC/JAL.
//    - rs2 used by R/STORE/BRANCH.
//  - loadUse = outValid && outMemRead && outRd!=0 && outRd matches a used rs of fd.
//    - Stall fd, hold instrReady=0; bubble once outReady drains the load.
//  - Illegal (opcode outside 0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111,1110011,0001111):
//    - passes through with outIllegal=1, regWrite/memRead/memWrite=0.
//  - Flush: next edge fdValid=0, outValid=0; overrides accept, advance and stall in the same cycle.
//  - Reset mid-operation: identical to flush plus data clear.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined:
//    - if wbRegWrite && wbWriteRegister==rs && rs!=0, operand = wbWriteData (same-cycle write bypass).
//  Undefined:
//    - wb* ports are ignored; operand = readData.
// STRUCTURE
//  - Header riscv_defs.vh: opcode localparams, instruction-format field positions, XLEN default.
//  - Sub-module imm_gen: combinational immediate generator (instr in, imm out).
// TESTING
//  1. Reset 2 cycles -> outValid=0, all out*=0, instrReady=1 cycle after release.
//  2. instr 0x00500093 (addi x1,x0,5) -> outImm=5, outOp1=0, outRd=1, outRegWrite=1, 1 cycle latency.
//  3. 0x002081B3 (add x3,x1,x2), readData1=7, readData2=9, readRegister1=1/2 -> outOp1=7, outOp2=9, outRd=3.
//  4. 0x0000A283 (lw x5,0(x1)) then 0x00528333 (add x6,x5,x5) -> one bubble; add on out* 1 cycle later than unstalled.
//  5. outReady=0 for 3 cycles with back-to-back stream -> out* stable, instrReady=0 once fd full, no loss or duplication.
//  6. flush with both stages full -> next edge outValid=0; 0xFFFFFFFF -> outIllegal=1; bypass wb x2=0xAB -> outOp2=0xAB.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - RV32I opcodes, instruction field positions and immediate formats
package decode_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    // Illegal opcodes fall into FMT_R so they carry no immediate.
    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM: return FMT_I;
            OPC_STORE:                return FMT_S;
            OPC_BRANCH:               return FMT_B;
            OPC_LUI, OPC_AUIPC:       return FMT_U;
            OPC_JAL:                  return FMT_J;
            default:                  return FMT_R;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - combinational RV32I immediate generator
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (fmt_of(i_instr[6:0]))
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage (IF/ID + ID/EX registers); DECODE_WB_BYPASS_EN adds writeback bypass
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instrValid,
    output logic               instrReady,
    input  logic [31:0]        instr,
    input  logic [PC_W-1:0]    pcIn,
    input  logic               flush,
    output logic [RADDR_W-1:0] readRegister1,
    output logic [RADDR_W-1:0] readRegister2,
    input  logic [XLEN-1:0]    readData1,
    input  logic [XLEN-1:0]    readData2,
    input  logic               wbRegWrite,
    input  logic [RADDR_W-1:0] wbWriteRegister,
    input  logic [XLEN-1:0]    wbWriteData,
    output logic               outValid,
    input  logic               outReady,
    output logic [PC_W-1:0]    outPc,
    output logic [XLEN-1:0]    outOp1,
    output logic [XLEN-1:0]    outOp2,
    output logic [XLEN-1:0]    outImm,
    output logic [RADDR_W-1:0] outRd,
    output logic [RADDR_W-1:0] outRs1,
    output logic [RADDR_W-1:0] outRs2,
    output logic [6:0]         outOpcode,
    output logic [2:0]         outFunct3,
    output logic [6:0]         outFunct7,
    output logic               outRegWrite,
    output logic               outMemRead,
    output logic               outMemWrite,
    output logic               outIllegal
);

    logic               r_fd_valid;
    logic [31:0]        r_fd_instr;
    logic [PC_W-1:0]    r_fd_pc;

    logic               r_out_valid;
    logic [PC_W-1:0]    r_out_pc;
    logic [XLEN-1:0]    r_out_op1, r_out_op2, r_out_imm;
    logic [RADDR_W-1:0] r_out_rd, r_out_rs1, r_out_rs2;
    logic [6:0]         r_out_opcode, r_out_funct7;
    logic [2:0]         r_out_funct3;
    logic               r_out_reg_write, r_out_mem_read, r_out_mem_write, r_out_illegal;

    logic [6:0]         w_opcode, w_funct7;
    logic [2:0]         w_funct3;
    logic [RADDR_W-1:0] w_rd, w_rs1, w_rs2;
    logic               w_legal, w_reg_write, w_mem_read, w_mem_write;
    logic               w_rs1_used, w_rs2_used;
    logic               w_load_use, w_advance, w_fire;
    logic [XLEN-1:0]    w_imm, w_op1, w_op2;

    assign w_opcode = r_fd_instr[6:0];
    assign w_rd     = r_fd_instr[RD_LSB +: RADDR_W];
    assign w_funct3 = r_fd_instr[F3_LSB +: 3];
    assign w_rs1    = r_fd_instr[RS1_LSB +: RADDR_W];
    assign w_rs2    = r_fd_instr[RS2_LSB +: RADDR_W];
    assign w_funct7 = r_fd_instr[F7_LSB +: 7];

    assign readRegister1 = w_rs1;
    assign readRegister2 = w_rs2;

    always_comb begin
        w_legal     = 1'b1;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_reg_write = 1'b1;
            OPC_LOAD: begin
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
            end
            OPC_STORE:                           w_mem_write = 1'b1;
            OPC_BRANCH, OPC_SYSTEM, OPC_MISC_MEM: w_legal    = 1'b1;
            default:                             w_legal    = 1'b0;
        endcase
    end

    assign w_rs1_used = !(w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign w_rs2_used = w_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

    // A load sitting in ID/EX cannot supply its result to the instruction behind it yet.
    assign w_load_use = r_out_valid && r_out_mem_read && (r_out_rd != '0) &&
                        ((w_rs1_used && (r_out_rd == w_rs1)) ||
                         (w_rs2_used && (r_out_rd == w_rs2)));

    assign w_advance  = r_fd_valid && !w_load_use && (!r_out_valid || outReady);
    assign instrReady = !reset && !flush && (!r_fd_valid || w_advance);
    assign w_fire     = instrValid && instrReady;

`ifdef DECODE_WB_BYPASS_EN
    assign w_op1 = (w_rs1 == '0) ? '0 :
                   (wbRegWrite && (wbWriteRegister == w_rs1)) ? wbWriteData : readData1;
    assign w_op2 = (w_rs2 == '0) ? '0 :
                   (wbRegWrite && (wbWriteRegister == w_rs2)) ? wbWriteData : readData2;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wbRegWrite, wbWriteRegister, wbWriteData};
    assign w_op1 = (w_rs1 == '0) ? '0 : readData1;
    assign w_op2 = (w_rs2 == '0) ? '0 : readData2;
`endif

    decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (r_fd_instr),
        .o_imm   (w_imm)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fd_valid <= 1'b0;
            r_fd_instr <= '0;
            r_fd_pc    <= '0;
        end else if (flush) begin
            r_fd_valid <= 1'b0;
        end else if (w_fire) begin
            r_fd_valid <= 1'b1;
            r_fd_instr <= instr;
            r_fd_pc    <= pcIn;
        end else if (w_advance) begin
            r_fd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= '0;
            r_out_op1       <= '0;
            r_out_op2       <= '0;
            r_out_imm       <= '0;
            r_out_rd        <= '0;
            r_out_rs1       <= '0;
            r_out_rs2       <= '0;
            r_out_opcode    <= '0;
            r_out_funct3    <= '0;
            r_out_funct7    <= '0;
            r_out_reg_write <= 1'b0;
            r_out_mem_read  <= 1'b0;
            r_out_mem_write <= 1'b0;
            r_out_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_advance) begin
            r_out_valid     <= 1'b1;
            r_out_pc        <= r_fd_pc;
            r_out_op1       <= w_op1;
            r_out_op2       <= w_op2;
            r_out_imm       <= w_imm;
            r_out_rd        <= w_rd;
            r_out_rs1       <= w_rs1;
            r_out_rs2       <= w_rs2;
            r_out_opcode    <= w_opcode;
            r_out_funct3    <= w_funct3;
            r_out_funct7    <= w_funct7;
            r_out_reg_write <= w_reg_write && w_legal;
            r_out_mem_read  <= w_mem_read && w_legal;
            r_out_mem_write <= w_mem_write && w_legal;
            r_out_illegal   <= !w_legal;
        end else if (r_out_valid && outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outValid    = r_out_valid;
    assign outPc       = r_out_pc;
    assign outOp1      = r_out_op1;
    assign outOp2      = r_out_op2;
    assign outImm      = r_out_imm;
    assign outRd       = r_out_rd;
    assign outRs1      = r_out_rs1;
    assign outRs2      = r_out_rs2;
    assign outOpcode   = r_out_opcode;
    assign outFunct3   = r_out_funct3;
    assign outFunct7   = r_out_funct7;
    assign outRegWrite = r_out_reg_write;
    assign outMemRead  = r_out_mem_read;
    assign outMemWrite = r_out_mem_write;
    assign outIllegal  = r_out_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a field-level RV32I reference model
module tb_decode_stage;

    localparam int XLEN = 32, PC_W = 32, RADDR_W = 5, OW = 164;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1, instrValid = 1'b0, flush = 1'b0, outReady = 1'b0;
    logic [31:0]        instr = '0;
    logic [PC_W-1:0]    pcIn = '0;
    logic               wbRegWrite = 1'b1;
    logic [RADDR_W-1:0] wbWriteRegister = 5'd2;
    logic [XLEN-1:0]    wbWriteData = 32'h000000AB;
    logic [XLEN-1:0]    rf [32];

    wire                instrReady, outValid;
    wire [RADDR_W-1:0]  readRegister1, readRegister2, outRd, outRs1, outRs2;
    wire [XLEN-1:0]     readData1, readData2, outOp1, outOp2, outImm;
    wire [PC_W-1:0]     outPc;
    wire [6:0]          outOpcode, outFunct7;
    wire [2:0]          outFunct3;
    wire                outRegWrite, outMemRead, outMemWrite, outIllegal;

    assign readData1 = rf[readRegister1];
    assign readData2 = rf[readRegister2];

    wire [OW-1:0] w_out = {outPc, outOp1, outOp2, outImm, outRd, outRs1, outRs2, outOpcode,
                           outFunct3, outFunct7, outRegWrite, outMemRead, outMemWrite, outIllegal};

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
        .instr(instr), .pcIn(pcIn), .flush(flush),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .readData1(readData1), .readData2(readData2),
        .wbRegWrite(wbRegWrite), .wbWriteRegister(wbWriteRegister), .wbWriteData(wbWriteData),
        .outValid(outValid), .outReady(outReady), .outPc(outPc), .outOp1(outOp1), .outOp2(outOp2),
        .outImm(outImm), .outRd(outRd), .outRs1(outRs1), .outRs2(outRs2), .outOpcode(outOpcode),
        .outFunct3(outFunct3), .outFunct7(outFunct7), .outRegWrite(outRegWrite),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outIllegal(outIllegal)
    );

    int checks = 0, errors = 0;
    logic [OW-1:0] exp_q [$];
    logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011,
                                   7'b0001111};

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] EXP_X2 = 32'h000000AB;
`else
    localparam logic [31:0] EXP_X2 = 32'd9;
`endif

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wbRegWrite && r == wbWriteRegister) return wbWriteData;
`endif
        return rf[r];
    endfunction

    // Expected ID/EX contents derived directly from the RV32I field definitions.
    function automatic logic [OW-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
        logic [6:0] op;
        logic legal, wr;
        logic signed [31:0] s;
        logic [31:0] imm;
        int sgn;
        op = ins[6:0];
        s = ins;
        sgn = (ins[31]) ? -1 : 0;
        legal = 1'b0;
        foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1'b1;
        wr = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                        7'b0110111, 7'b0010111};
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: imm = 32'(s >>> 20);
            7'b0100011: imm = 32'(int'(s >>> 25) * 32 + int'(ins[11:7]));
            7'b1100011: imm = 32'(sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                                  + int'(ins[11:8]) * 2);
            7'b0110111, 7'b0010111: imm = ins & 32'hFFFFF000;
            7'b1101111: imm = 32'(sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                                  + int'(ins[30:21]) * 2);
            default: imm = 32'd0;
        endcase
        return {pc, opnd(ins[19:15]), opnd(ins[24:20]), imm, ins[11:7], ins[19:15], ins[24:20],
                op, ins[14:12], ins[31:25], wr, op == 7'b0000011, op == 7'b0100011, !legal};
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int pick;
        w = $urandom;
        pick = $urandom_range(0, 11);
        if (pick < 11) w[6:0] = legal_ops[pick];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // One clock: drive inputs, record the expected result of any accepted instruction, advance.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ordy);
        instrValid = iv; instr = ins; pcIn = pc; flush = fl; outReady = ordy;
        #1;
        if (reset || flush) exp_q.delete();
        else if (instrValid && instrReady) exp_q.push_back(model(ins, pc));
        @(negedge clk);
    endtask

    initial begin : monitor
        logic hold_pend;
        logic [OW-1:0] hold_val;
        hold_pend = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            #3;
            if (hold_pend) begin
                chk("hold_valid", outValid, 1'b1);
                chk("hold_data", w_out, hold_val);
            end
            hold_pend = 1'b0;
            if (!reset && !flush && outValid) begin
                if (outReady) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_extra actual=%0h expected=none", w_out);
                    end else begin
                        chk("sb", w_out, exp_q.pop_front());
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_val = w_out;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] pc;
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = 32'hDEADBEEF;
        rf[1] = 32'd7;
        rf[2] = 32'd9;

        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_out", w_out, '0);
        chk("rst_instrReady", instrReady, 1'b0);
        reset = 1'b0;
        #1;
        chk("rel_instrReady", instrReady, 1'b1);

        step(1, 32'h00500093, 32'h100, 0, 1);
        chk("addi_latency", outValid, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("addi_valid", outValid, 1'b1);
        chk("addi_imm", outImm, 32'd5);
        chk("addi_op1", outOp1, 32'd0);
        chk("addi_rd", outRd, 5'd1);
        chk("addi_regwrite", outRegWrite, 1'b1);

        step(1, 32'h002081B3, 32'h104, 0, 1);
        chk("add_rr1", readRegister1, 5'd1);
        chk("add_rr2", readRegister2, 5'd2);
        step(0, 0, 0, 0, 1);
        chk("add_op1", outOp1, 32'd7);
        chk("add_op2", outOp2, EXP_X2);
        chk("add_rd", outRd, 5'd3);

        step(1, 32'h0000A283, 32'h108, 0, 1);
        step(1, 32'h00528333, 32'h10C, 0, 1);
        chk("lu_load_out", {outValid, outMemRead, outRd}, {1'b1, 1'b1, 5'd5});
        chk("lu_stall", instrReady, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("lu_bubble", outValid, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("lu_add_out", {outValid, outRd}, {1'b1, 5'd6});
        step(0, 0, 0, 0, 1);

        pc = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            step(1, gen(), pc, 0, 0);
            pc += 4;
            if (i == 1) chk("bp_full_ready", instrReady, 1'b0);
        end
        chk("bp_still_full", instrReady, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1, gen(), pc, 0, 1);
            pc += 4;
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        step(1, gen(), pc, 0, 0);
        step(1, gen(), pc + 4, 0, 0);
        chk("fl_pre_valid", outValid, 1'b1);
        step(1, gen(), pc + 8, 1, 1);
        chk("fl_out_killed", outValid, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("fl_fd_killed", outValid, 1'b0);

        step(1, 32'hFFFFFFFF, 32'h200, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("ill_flag", outIllegal, 1'b1);
        chk("ill_ctrl", {outRegWrite, outMemRead, outMemWrite}, 3'b000);
        step(0, 0, 0, 0, 1);

        pc = 32'h4000;
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0), gen(), pc, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0));
            pc += 4;
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);

        step(1, gen(), pc, 0, 0);
        step(1, gen(), pc + 4, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("midrst_valid", outValid, 1'b0);
        chk("midrst_out", w_out, '0);
        reset = 1'b0;
        step(0, 0, 0, 0, 1);
        chk("midrst_fd_empty", outValid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
